// File: rtl/pending_encoder.sv
// Sticky 32-bit request collector that offers one pending index at a time
// over a valid/ready handshake, with fixed or rotating priority.
module pending_encoder #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_in,
    input  logic        enable,
    input  logic        ready,
    output logic [4:0]  idx_out,
    output logic        valid,
    output logic [31:0] pending,
    output logic        dup_pulse
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        dup_q, dup_d;
    logic [4:0]  ptr_q, ptr_d;

    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic        hs;
    logic [4:0]  start;
    logic [4:0]  k;
    logic [4:0]  hit_idx;
    logic        hit;

    assign hs      = valid_q && ready;
    assign set_vec = enable ? req_in : 32'd0;
    assign clr_vec = hs ? (32'd1 << idx_q) : 32'd0;
    assign start   = ROUND_ROBIN ? ptr_q : 5'd0;

    // Circular search upward from start; the 5-bit add wraps 31 -> 0.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 5'd0;
        k       = 5'd0;
        for (int i = 0; i < 32; i++) begin
            k = start + 5'(i);
            if (!hit && pending_q[k]) begin
                hit     = 1'b1;
                hit_idx = k;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        dup_d     = |(set_vec & pending_q & ~clr_vec);
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (hit) begin
                    state_d = OFFER;
                    idx_d   = hit_idx;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                valid_d = 1'b1;
                if (hs) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    if (ROUND_ROBIN) begin
                        ptr_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 32'd0;
            idx_q     <= 5'd0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
            ptr_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            dup_q     <= dup_d;
            ptr_q     <= ptr_d;
        end
    end

    assign idx_out   = idx_q;
    assign valid     = valid_q;
    assign pending   = pending_q;
    assign dup_pulse = dup_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Scoreboarded bench for pending_encoder: one rotating-priority and one
// fixed-priority instance, directed vectors with hand-computed grant orders.
module tb_pending_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;

    logic [31:0] req_a, req_b;
    logic        ready_a, ready_b;
    logic [4:0]  idx_a, idx_b;
    logic        valid_a, valid_b;
    logic [31:0] pend_a, pend_b;
    logic        dup_a, dup_b;

    logic [4:0]  qa[$];
    logic [4:0]  qb[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pending_encoder #(.ROUND_ROBIN(1'b1)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_in   (req_a),
        .enable   (enable),
        .ready    (ready_a),
        .idx_out  (idx_a),
        .valid    (valid_a),
        .pending  (pend_a),
        .dup_pulse(dup_a)
    );

    pending_encoder #(.ROUND_ROBIN(1'b0)) u_fix (
        .clk      (clk),
        .reset    (reset),
        .req_in   (req_b),
        .enable   (enable),
        .ready    (ready_b),
        .idx_out  (idx_b),
        .valid    (valid_b),
        .pending  (pend_b),
        .dup_pulse(dup_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a grant is taken whenever valid && ready is seen mid-cycle.
    always @(negedge clk) begin
        if (!reset && valid_a && ready_a) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL grant_rr: unexpected idx %0d, expected none", idx_a);
            end else begin
                logic [4:0] e;
                e = qa.pop_front();
                if (idx_a !== e) begin
                    n_fail++;
                    $display("FAIL grant_rr: got idx %0d expected %0d", idx_a, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && valid_b && ready_b) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL grant_fix: unexpected idx %0d, expected none", idx_b);
            end else begin
                logic [4:0] e;
                e = qb.pop_front();
                if (idx_b !== e) begin
                    n_fail++;
                    $display("FAIL grant_fix: got idx %0d expected %0d", idx_b, e);
                end
            end
        end
    end

    task automatic drain_a(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || valid_a || pend_a != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 200), 32'd1);
    endtask

    task automatic drain_b(input string name);
        int n;
        n = 0;
        while ((qb.size() != 0 || valid_b || pend_b != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        req_a   = '0;
        req_b   = '0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_pending", pend_a, 32'd0);
        chk("rst_dup", 32'(dup_a), 32'd0);
        chk("rst_valid_fix", 32'(valid_b), 32'd0);
        reset = 1'b0;

        // Single request, ready held: offer two cycles later.
        enable  = 1'b1;
        ready_a = 1'b1;
        req_a   = 32'h0000_0001;
        qa.push_back(5'd0);
        tick();
        req_a = '0;
        chk("t1_pend", pend_a, 32'h1);
        chk("t1_nvalid", 32'(valid_a), 32'd0);
        tick();
        chk("t1_valid", 32'(valid_a), 32'd1);
        chk("t1_idx", 32'(idx_a), 32'd0);
        tick();
        chk("t1_pend0", pend_a, 32'd0);
        chk("t1_valid0", 32'(valid_a), 32'd0);

        // Rotating order from ptr 0, then wrap back to 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 32'h8000_0011;
        qa.push_back(5'd0);
        qa.push_back(5'd4);
        qa.push_back(5'd31);
        tick();
        req_a = '0;
        drain_a("t2_drain1");
        req_a = 32'h0000_0011;
        qa.push_back(5'd0);
        qa.push_back(5'd4);
        tick();
        req_a = '0;
        drain_a("t2_drain2");

        // Duplicate request, then set-wins against the handshake clear.
        ready_a = 1'b0;
        req_a   = 32'h0000_0200;
        qa.push_back(5'd9);
        qa.push_back(5'd9);
        tick();
        req_a = '0;
        tick();
        chk("t5_valid", 32'(valid_a), 32'd1);
        chk("t5_idx", 32'(idx_a), 32'd9);
        req_a = 32'h0000_0200;
        tick();
        chk("t5_dup1", 32'(dup_a), 32'd1);
        req_a = '0;
        tick();
        chk("t5_dup0", 32'(dup_a), 32'd0);
        ready_a = 1'b1;
        req_a   = 32'h0000_0200;
        tick();
        req_a = '0;
        chk("t5_pend_kept", pend_a, 32'h0000_0200);
        chk("t5_dup_hs", 32'(dup_a), 32'd0);
        chk("t5_bubble", 32'(valid_a), 32'd0);
        drain_a("t5_drain");

        // Offer held stable under back-pressure; ptr=10 wraps to 5, then 1.
        ready_a = 1'b0;
        req_a   = 32'h0000_0020;
        qa.push_back(5'd5);
        qa.push_back(5'd1);
        tick();
        req_a = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_valid", 32'(valid_a), 32'd1);
            chk("t4_hold_idx", 32'(idx_a), 32'd5);
            req_a = (i == 1) ? 32'h0000_0002 : 32'd0;
            tick();
        end
        req_a   = '0;
        ready_a = 1'b1;
        tick();
        chk("t4_pend", pend_a, 32'h0000_0002);
        chk("t4_bubble", 32'(valid_a), 32'd0);
        drain_a("t4_drain");

        // Fixed priority: re-pulsed bit 3 beats the older bit 7.
        ready_b = 1'b1;
        req_b   = 32'h0000_0088;
        qb.push_back(5'd3);
        qb.push_back(5'd3);
        qb.push_back(5'd7);
        tick();
        req_b = '0;
        tick();
        chk("t3_idx", 32'(idx_b), 32'd3);
        req_b = 32'h0000_0008;
        tick();
        req_b = '0;
        chk("t3_pend", pend_b, 32'h0000_0088);
        drain_b("t3_drain");

        // Reset in the middle of an offer, then enable=0 blocks latching.
        ready_a = 1'b0;
        req_a   = 32'hFFFF_FFFF;
        tick();
        req_a = '0;
        tick();
        chk("t6_valid", 32'(valid_a), 32'd1);
        chk("t6_pend", pend_a, 32'hFFFF_FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", 32'(valid_a), 32'd0);
        chk("t6_rst_pend", pend_a, 32'd0);
        chk("t6_rst_idx", 32'(idx_a), 32'd0);
        enable  = 1'b0;
        ready_a = 1'b1;
        req_a   = 32'h0000_00FF;
        tick();
        req_a = '0;
        chk("t6_nolatch", pend_a, 32'd0);
        tick();
        chk("t6_novalid", 32'(valid_a), 32'd0);

        chk("sb_empty_rr", 32'(qa.size()), 32'd0);
        chk("sb_empty_fix", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pending_encoder.md
Name: pending_encoder

Overview:
- Converts a 32-bit request vector into a sequence of 5-bit indices, one request at a time. It is the reverse of the 5-to-32 one-hot select decoder.
- Requests are latched into a sticky pending register. The block offers one index at a time on a valid/ready handshake.
- Each accepted index clears its pending bit.
- Sits between multi-source event lines (trap causes, register-file scoreboard releases) and any consumer that needs a binary index.

Parameters:
- ROUND_ROBIN, 1: 1 selects rotating priority starting at last-granted index + 1. 0 selects fixed priority, lowest index wins.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_in  input  32  request set pulses; bit i set means request i. Sampled only when enable = 1.
- enable  input  1  gates req_in. When 0, no new bits are latched; pending bits are still served.
- ready  input  1  consumer accepts the offered index this cycle.
- idx_out  output  5  index currently offered (binary).
- valid  output  1  idx_out is meaningful.
- pending  output  32  current pending register.
- dup_pulse  output  1  one-cycle flag: a request arrived for a bit already pending and not being cleared.

Behaviour:
- Reset (sync, active-high), in the same cycle:
  - pending = 0, valid = 0, idx_out = 0, dup_pulse = 0, ptr = 0, state = IDLE.
  - Reset asserted mid-offer discards the offer and all pending bits. No handshake completes in a reset cycle.
- Pending update, every cycle:
  - pending_next = (pending & ~clr) | (enable ? req_in : 0).
  - clr is the one-hot of idx_out when valid && ready, else 0.
  - If set and clear hit the same bit in the same cycle, set wins: the bit stays pending.
- dup_pulse (registered) = 1 if any bit of (enable ? req_in : 0) & pending & ~clr is 1.
- FSM with two states, IDLE and OFFER:
  - IDLE: if registered pending != 0, go to OFFER.
    - Load idx_out = first set bit searching upward from ptr, wrapping 31 -> 0. ROUND_ROBIN = 0 forces the search start to 0.
    - Set valid = 1.
    - Else stay in IDLE with valid = 0.
  - OFFER: valid = 1, and idx_out is held stable until the handshake.
    - On valid && ready: clear bit idx_out in pending, set valid = 0, and go to IDLE.
    - Also set ptr = idx_out + 1 mod 32 (wraps 31 -> 0). ptr is unchanged when ROUND_ROBIN = 0.
    - A new request arriving during OFFER never changes idx_out.
- Latency and throughput:
  - req_in at cycle t -> pending bit at t+1 -> valid with idx_out at t+2, provided the FSM is in IDLE.
  - Maximum throughput is one grant per 2 cycles: one mandatory IDLE bubble after each handshake.
- ready while valid = 0 is ignored.
- All 32 bits pending and served round-robin: each index is granted exactly once per 32 grants, with no starvation.
- enable = 0 with pending != 0: the block keeps draining the pending bits.
- pending = 0 in IDLE: valid stays 0 and idx_out holds its last value.
- All outputs are registered. There is no combinational path from req_in or ready to any output.

Test Plan:
- Reset, then req_in = 0x0000_0001 for one cycle with enable = 1 and ready = 1 held -> valid = 1, idx_out = 0 two cycles later. Next cycle pending = 0 and valid = 0.
- ROUND_ROBIN = 1, req_in = 0x8000_0011 pulsed once, ready = 1 -> grants in order 0, 4, 31. After that, req_in = 0x0000_0011 -> grant order 0 (from ptr = 0 after wrap), then 4.
- ROUND_ROBIN = 0, pending bits 3 and 7, after bit 3 is served re-pulse bit 3 -> next grant is 3 again, not 7.
- OFFER idx_out = 5 with ready = 0 for 4 cycles while req_in = 0x0000_0002 pulses -> idx_out stays 5 and valid stays 1. When ready = 1, pending = 0x0000_0002 and the next grant is 1 (after 5 wraps round-robin... ptr = 6, search wraps to 1).
- Bit 9 pending; pulse req_in bit 9 -> dup_pulse = 1 for one cycle. Handshake on 9 with req_in bit 9 in the same cycle -> bit 9 remains pending, dup_pulse = 0, and 9 is granted again.
- Mid-offer with pending = 0xFFFF_FFFF, assert reset for 1 cycle -> next cycle valid = 0, pending = 0, idx_out = 0. With enable = 0 and a req_in pulse, nothing is latched.
